// File: rtl/dual_da_rom_sched.sv
// dual_da_rom_sched: shares one single-port waveform ROM between two DDS
// channels by alternating issue slots, then routes returned data to the
// matching DA output. Configuration is double-buffered per channel.
module dual_da_rom_sched #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 10,
  parameter int ACC_W    = 32,
  parameter int RD_LAT   = 2,
  parameter int MIDSCALE = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch0_en,
  input  logic              ch1_en,
  input  logic [ACC_W-1:0]  ch0_fword,
  input  logic [ACC_W-1:0]  ch1_fword,
  input  logic [ADDR_W-1:0] ch0_poff,
  input  logic [ADDR_W-1:0] ch1_poff,
  input  logic              cfg_load,
  input  logic              phase_sync,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              da_clk0,
  output logic [DATA_W-1:0] da_data0,
  output logic              da_clk1,
  output logic [DATA_W-1:0] da_data1
);

  localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE);
  localparam int                LAST = RD_LAT - 1;

  // slot=0: channel 0 owns this edge's ROM issue, slot=1: channel 1
  logic              slot;

  logic [ACC_W-1:0]  acc0, acc1;
  logic [ACC_W-1:0]  fw_act0, fw_act1, fw_pend0, fw_pend1;
  logic [ADDR_W-1:0] po_act0, po_act1, po_pend0, po_pend1;
  logic              pend0, pend1, sync0, sync1;

  logic [RD_LAT-1:0] tag_vld, tag_ch, tag_idle;

  logic              iss_en, iss_pend, iss_sync;
  logic [ACC_W-1:0]  iss_acc, iss_fw, acc_base, acc_next;
  logic [ADDR_W-1:0] iss_po, iss_addr;
  logic              cap0, cap1;

  // Select the issuing channel and resolve pending config / sync for it.
  // A pending load or sync only exists here if it was registered on an
  // earlier edge, so a load coinciding with an issue uses the old values.
  always_comb begin
    iss_en   = slot ? ch1_en : ch0_en;
    iss_pend = slot ? pend1 : pend0;
    iss_sync = slot ? sync1 : sync0;
    iss_acc  = slot ? acc1 : acc0;
    iss_fw   = slot ? (pend1 ? fw_pend1 : fw_act1) : (pend0 ? fw_pend0 : fw_act0);
    iss_po   = slot ? (pend1 ? po_pend1 : po_act1) : (pend0 ? po_pend0 : po_act0);
    acc_base = iss_sync ? '0 : iss_acc;
    iss_addr = acc_base[ACC_W-1 -: ADDR_W] + iss_po;
    acc_next = iss_en ? acc_base + iss_fw : '0;
  end

  assign cap0 = tag_vld[LAST] && !tag_ch[LAST];
  assign cap1 = tag_vld[LAST] &&  tag_ch[LAST];

  // Shadow capture: last cfg_load before application wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fw_pend0 <= '0;
      fw_pend1 <= '0;
      po_pend0 <= '0;
      po_pend1 <= '0;
    end else if (cfg_load) begin
      fw_pend0 <= ch0_fword;
      fw_pend1 <= ch1_fword;
      po_pend0 <= ch0_poff;
      po_pend1 <= ch1_poff;
    end
  end

  // Slot alternation, ROM address issue, accumulators and per-channel flags.
  // A new cfg_load/phase_sync on the issuing edge re-arms the flag for the
  // following issue, so set has priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot     <= 1'b0;
      rom_addr <= '0;
      acc0     <= '0;
      acc1     <= '0;
      fw_act0  <= '0;
      fw_act1  <= '0;
      po_act0  <= '0;
      po_act1  <= '0;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      sync0    <= 1'b0;
      sync1    <= 1'b0;
    end else begin
      slot     <= ~slot;
      rom_addr <= iss_addr;
      if (!slot) begin
        acc0 <= acc_next;
        if (iss_pend) begin
          fw_act0 <= fw_pend0;
          po_act0 <= po_pend0;
        end
        pend0 <= cfg_load;
        sync0 <= phase_sync;
        pend1 <= pend1 | cfg_load;
        sync1 <= sync1 | phase_sync;
      end else begin
        acc1 <= acc_next;
        if (iss_pend) begin
          fw_act1 <= fw_pend1;
          po_act1 <= po_pend1;
        end
        pend1 <= cfg_load;
        sync1 <= phase_sync;
        pend0 <= pend0 | cfg_load;
        sync0 <= sync0 | phase_sync;
      end
    end
  end

  // Tag pipe tracks which channel each in-flight ROM read belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_ch   <= '0;
      tag_idle <= '0;
    end else begin
      tag_vld[0]  <= 1'b1;
      tag_ch[0]   <= slot;
      tag_idle[0] <= ~iss_en;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_ch[i]   <= tag_ch[i-1];
        tag_idle[i] <= tag_idle[i-1];
      end
    end
  end

  // DA outputs: capture on the returning tag, drop da_clk with new data so
  // its rising edge lands in the middle of the data window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      da_data0 <= MID;
      da_data1 <= MID;
      da_clk0  <= 1'b0;
      da_clk1  <= 1'b0;
    end else begin
      if (cap0) begin
        da_data0 <= tag_idle[LAST] ? MID : rom_data;
        da_clk0  <= 1'b0;
      end else begin
        da_clk0  <= 1'b1;
      end
      if (cap1) begin
        da_data1 <= tag_idle[LAST] ? MID : rom_data;
        da_clk1  <= 1'b0;
      end else begin
        da_clk1  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dual_da_rom_sched.sv
// Directed bench for dual_da_rom_sched: one instance at RD_LAT=2 and one at
// RD_LAT=3 share stimulus; each has its own synchronous ROM model.
module tb_dual_da_rom_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ch0_en, ch1_en, cfg_load, phase_sync;
  logic [31:0] ch0_fword, ch1_fword;
  logic [9:0]  ch0_poff, ch1_poff;

  logic [9:0]  rom_addr2, rom_data2, da_data0_2, da_data1_2;
  logic        da_clk0_2, da_clk1_2;
  logic [9:0]  rom_addr3, rom_data3, da_data0_3, da_data1_3;
  logic        da_clk0_3, da_clk1_3;
  logic [9:0]  rom_q2, rom3_s0, rom3_s1;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  function automatic logic [9:0] rom_f(input logic [9:0] a);
    return a ^ 10'h155;
  endfunction

  // ROM models: RD_LAT-1 register stages after the address register
  always @(posedge clk) begin
    rom_q2  <= rom_f(rom_addr2);
    rom3_s0 <= rom_f(rom_addr3);
    rom3_s1 <= rom3_s0;
  end
  assign rom_data2 = rom_q2;
  assign rom_data3 = rom3_s1;

  dual_da_rom_sched #(.RD_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .ch0_en(ch0_en), .ch1_en(ch1_en),
    .ch0_fword(ch0_fword), .ch1_fword(ch1_fword),
    .ch0_poff(ch0_poff), .ch1_poff(ch1_poff),
    .cfg_load(cfg_load), .phase_sync(phase_sync),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .da_clk0(da_clk0_2), .da_data0(da_data0_2),
    .da_clk1(da_clk1_2), .da_data1(da_data1_2)
  );

  dual_da_rom_sched #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .ch0_en(ch0_en), .ch1_en(ch1_en),
    .ch0_fword(ch0_fword), .ch1_fword(ch1_fword),
    .ch0_poff(ch0_poff), .ch1_poff(ch1_poff),
    .cfg_load(cfg_load), .phase_sync(phase_sync),
    .rom_addr(rom_addr3), .rom_data(rom_data3),
    .da_clk0(da_clk0_3), .da_data0(da_data0_3),
    .da_clk1(da_clk1_3), .da_data1(da_data1_3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    edge_n = 0;
  endtask

  int exp_t1[7] = '{0, 0, 0, 1, 1, 2, 2};

  initial begin
    ch0_en = 1'b1; ch1_en = 1'b1; cfg_load = 1'b0; phase_sync = 1'b0;
    ch0_fword = '0; ch1_fword = '0; ch0_poff = '0; ch1_poff = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_rom_addr", rom_addr2, 0);
    chk("rst_da_data0", da_data0_2, 512);
    chk("rst_da_data1", da_data1_2, 512);
    chk("rst_da_clk0", da_clk0_2, 0);
    tick();
    rst = 1'b0;
    edge_n = 0;

    // 1: both 1 ROM step per issue; config lands with the first issue edge
    ch0_fword = 32'd1 << 22; ch1_fword = 32'd1 << 22;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t1_da_clk0_e1", da_clk0_2, 1);
    chk("t1_da_data0_e1", da_data0_2, 512);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk("t1_addr", rom_addr2, exp_t1[i]);
      if (edge_n == 3) begin
        chk("t1_da_data0_e3", da_data0_2, rom_f(10'd0));
        chk("t1_da_clk0_e3", da_clk0_2, 0);
      end
      if (edge_n == 4) begin
        chk("t1_da_clk0_e4", da_clk0_2, 1);
        chk("t1_da_data1_e4", da_data1_2, rom_f(10'd0));
        chk("t1_da_clk1_e4", da_clk1_2, 0);
      end
      if (edge_n == 5) chk("t1_da_clk0_e5", da_clk0_2, 0);
      if (edge_n == 7) chk("t1_da_data0_e7", da_data0_2, rom_f(10'd1));
    end

    // 2: ch1 steps by 2, wraps 1022 -> 0
    do_reset();
    ch1_fword = 32'd1 << 23;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    step_to(4);
    chk("t2_ch1_addr_e4", rom_addr2, 2);
    step_to(6);
    chk("t2_da_data1_e6", da_data1_2, rom_f(10'd2));
    step_to(1024);
    chk("t2_ch1_addr_1022", rom_addr2, 1022);
    tick();
    chk("t2_ch0_addr_511", rom_addr2, 511);
    tick();
    chk("t2_ch1_wrap_0", rom_addr2, 0);

    // 3: cfg_load on ch0 issue edge E1027
    cfg_load = 1'b1; ch0_poff = 10'd256; ch1_poff = 10'd100;
    tick();
    cfg_load = 1'b0;
    chk("t3_ch0_old", rom_addr2, 512);
    tick();
    chk("t3_ch1_new", rom_addr2, 102);
    tick();
    chk("t3_ch0_new", rom_addr2, 769);
    step_to(1031);
    chk("t3_ch0_next", rom_addr2, 770);

    // 4: ch1 disable / re-enable
    ch1_en = 1'b0;
    tick();
    chk("t4_addr_e1032", rom_addr2, 106);
    chk("t4_d1_before", da_data1_2, rom_f(10'd104));
    step_to(1034);
    chk("t4_d1_mid", da_data1_2, 512);
    tick();
    chk("t4_d0_unaff", da_data0_2, rom_f(10'd771));
    tick();
    chk("t4_d1_hold", da_data1_2, 512);
    ch1_en = 1'b1;
    step_to(1038);
    chk("t4_reen_addr", rom_addr2, 100);
    step_to(1040);
    chk("t4_reen_addr2", rom_addr2, 102);
    chk("t4_reen_data", da_data1_2, rom_f(10'd100));

    // 5: phase_sync registered on a ch1 issue edge
    step_to(1241);
    phase_sync = 1'b1;
    tick();
    phase_sync = 1'b0;
    tick();
    chk("t5_ch0_sync", rom_addr2, 256);
    tick();
    chk("t5_ch1_sync", rom_addr2, 100);
    tick();
    chk("t5_ch0_step", rom_addr2, 257);
    tick();
    chk("t5_ch1_step", rom_addr2, 102);

    // 6: mid-stream reset on RD_LAT=3 instance
    rst = 1'b1;
    #1;
    chk("t6_rst_addr", rom_addr3, 0);
    chk("t6_rst_d0", da_data0_3, 512);
    chk("t6_rst_d1", da_data1_3, 512);
    chk("t6_rst_clk0", da_clk0_3, 0);
    chk("t6_rst_clk1", da_clk1_3, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i <= 3) chk("t6_d0_nostale", da_data0_3, 512);
      else chk("t6_d0_first", da_data0_3, rom_f(10'd0));
      if (i <= 4) chk("t6_d1_nostale", da_data1_3, 512);
      else chk("t6_d1_first", da_data1_3, rom_f(10'd0));
    end
    chk("t6_clk1_e5", da_clk1_3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
